// File: rtl/inst_rom.sv
// Instruction memory for the Naive_CPU fetch port, with a byte-serial framed loader
// that fills the memory and holds the CPU in reset while a load is running.
module inst_rom #(
  parameter int unsigned              ADDR_W   = 8,
  parameter int unsigned              INST_W   = 16,
  parameter logic [INST_W-1:0]        NOP_WORD = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rom_ce_i,
  input  logic [15:0]         rom_addr_i,
  output logic [INST_W-1:0]   rom_data_o,
  input  logic                ld_start_i,
  input  logic                ld_valid_i,
  input  logic [7:0]          ld_byte_i,
  output logic                ld_ready_o,
  output logic                ld_done_o,
  output logic                ld_err_o,
  output logic [ADDR_W:0]     ld_count_o,
  output logic                cpu_rst_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    RUN   = 3'd0,
    HDR_H = 3'd1,
    HDR_L = 3'd2,
    W_H   = 3'd3,
    W_L   = 3'd4,
    DONE  = 3'd5,
    ERR   = 3'd6
  } state_e;

  state_e              state_q, state_d;
  logic [15:0]         n_q, n_d;
  logic [7:0]          hi_q, hi_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ready_q, ready_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                accept;
  logic                wr_en;
  logic [15:0]         n_full;
  logic [INST_W-1:0]   mem_q [DEPTH];

  // A byte moves only when offered, accepted, and not overridden by a start.
  assign accept = ld_valid_i & ready_q & ~ld_start_i;
  assign n_full = {n_q[15:8], ld_byte_i};

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    hi_d    = hi_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    if (ld_start_i) begin
      state_d = HDR_H;
      cnt_d   = '0;
    end else begin
      case (state_q)
        HDR_H: if (accept) begin
          n_d[15:8] = ld_byte_i;
          state_d   = HDR_L;
        end
        HDR_L: if (accept) begin
          n_d = n_full;
          if ((n_full == 16'd0) || (32'(n_full) > DEPTH)) state_d = ERR;
          else                                            state_d = W_H;
        end
        W_H: if (accept) begin
          hi_d    = ld_byte_i;
          state_d = W_L;
        end
        W_L: if (accept) begin
          wr_en = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
          if ((32'(cnt_q) + 32'd1) == 32'(n_q)) state_d = DONE;
          else                                  state_d = W_H;
        end
        DONE:    state_d = RUN;
        default: state_d = state_q;
      endcase
    end
    ready_d = (state_d == HDR_H) || (state_d == HDR_L) ||
              (state_d == W_H)   || (state_d == W_L);
    done_d  = (state_d == DONE);
    err_d   = (state_d == ERR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      n_q     <= '0;
      hi_q    <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      hi_q    <= hi_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Storage is never cleared; the loaded length alone decides what is visible.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[cnt_q[ADDR_W-1:0]] <= {hi_q, ld_byte_i};
  end

  // Zero-latency fetch; the word count doubles as the visible length.
  always_comb begin
    rom_data_o = NOP_WORD;
    if (rom_ce_i && (32'(rom_addr_i) < 32'(cnt_q)))
      rom_data_o = mem_q[rom_addr_i[ADDR_W-1:0]];
  end

  assign ld_ready_o = ready_q;
  assign ld_done_o  = done_q;
  assign ld_err_o   = err_q;
  assign ld_count_o = cnt_q;
  assign cpu_rst_o  = rst | (state_q != RUN);

endmodule

// File: doc/inst_rom.md
Name: inst_rom

Overview:
- Instruction memory that answers the Naive_CPU fetch port: takes the fetch address and chip enable, returns the 16-bit instruction word.
- Also contains a byte-serial program loader, with a valid/ready handshake and a framing state machine, that fills the memory.
- Holds the CPU in reset while a load is in progress.
- Sits beside Naive_CPU at SoC/bench top level. It replaces the constant instruction value currently driven into rom_data_i.

Parameters:
- ADDR_W, 8, word-address bits; depth = 2**ADDR_W words (256).
- INST_W, 16, instruction width; must match the CPU instruction bus.
- NOP_WORD, 16'h0000, value returned for disabled or unloaded reads.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- rom_ce_i  input  1  fetch enable, from CPU rom_ce_o.
- rom_addr_i  input  16  fetch word address, from CPU rom_addr_o.
- rom_data_o  output  INST_W  instruction word, to CPU rom_data_i.
- ld_start_i  input  1  single-cycle pulse: begin a new load (aborts any load in progress).
- ld_valid_i  input  1  ld_byte_i holds a valid byte.
- ld_byte_i  input  8  load byte stream.
- ld_ready_o  output  1  loader can accept a byte.
- ld_done_o  output  1  single-cycle pulse: load completed successfully.
- ld_err_o  output  1  level: bad header; stays high until the next ld_start_i or rst.
- ld_count_o  output  ADDR_W+1  words written in the current or last load.
- cpu_rst_o  output  1  reset to Naive_CPU; high while loading.

Behaviour:
- Reset (async): state RUN, loaded_len=0, ld_count_o=0, ld_ready_o=0, ld_done_o=0, ld_err_o=0, cpu_rst_o=1 while rst is asserted. Memory contents are not cleared; loaded_len=0 hides them.
- Read path is combinational, with zero-cycle latency, to match single-cycle IF:
  - rom_data_o = mem[rom_addr_i[ADDR_W-1:0]] when rom_ce_i=1 and the full 16-bit rom_addr_i < loaded_len.
  - Otherwise rom_data_o = NOP_WORD. Addresses at or beyond depth always return NOP_WORD.
- Byte transfer: a byte is accepted on a rising edge where ld_valid_i=1 and ld_ready_o=1. ld_ready_o is a registered state decode: 1 in HDR_H, HDR_L, W_H and W_L; 0 in every other state.
- Frame format: N_hi, N_lo, then N words, each sent high byte first. N is the 16-bit word count.
- State machine:
  - RUN: cpu_rst_o=0 (after rst deasserts). ld_start_i -> HDR_H; loaded_len<=0, ld_count_o<=0, ld_err_o<=0.
  - HDR_H: on accept, latch N[15:8] -> HDR_L.
  - HDR_L: on accept, latch N[7:0] and check the full 16-bit N.
    - N==0 or N>2**ADDR_W -> ERR.
    - Otherwise -> W_H.
  - W_H: on accept, latch the high byte -> W_L.
  - W_L: on accept, write {hi,lo} to mem[ld_count_o]; ld_count_o++ and loaded_len++ on the same edge.
    - If the incremented count == N -> DONE.
    - Otherwise -> W_H.
  - DONE: lasts one cycle; ld_done_o=1 -> RUN.
  - ERR: ld_err_o=1, loaded_len stays 0. Only ld_start_i (-> HDR_H) or rst leaves ERR.
- cpu_rst_o = rst OR (state != RUN). This includes DONE, so the CPU leaves reset on the cycle after the ld_done_o pulse.
- ld_start_i in any state other than RUN or ERR aborts the load and restarts at HDR_H with counters cleared. The partially written words become invisible (loaded_len=0).
- ld_start_i and ld_valid_i in the same cycle: the start wins and the byte is not accepted.
- Stalls: when ld_valid_i is low, the state holds indefinitely; there is no timeout.
- N == depth (256) is legal. The last write goes to address 255 and ld_count_o reaches 256, hence the ADDR_W+1 width.
- Async rst during a load: the state returns to RUN with loaded_len=0, so every fetch returns NOP_WORD until a successful load.

Test Plan:
- Post-reset read: rst for 40 ns, then rom_ce_i=1, rom_addr_i=0 -> rom_data_o=16'h0000 and cpu_rst_o=0.
- Basic load: start, bytes 00 02 34 43 12 34 with ld_valid_i held high -> mem[0]=16'h3443, mem[1]=16'h1234.
  - One ld_done_o pulse appears on the 7th edge after start; cpu_rst_o falls one cycle later.
  - After release, reads of addr 0/1/2 -> 3443/1234/0000.
- Back-pressure and stalls: same frame with ld_valid_i toggling randomly -> identical memory contents; ld_count_o steps 0->1->2 only on W_L accepts.
- Bad headers:
  - N=0 -> ld_err_o=1, ld_ready_o=0, cpu_rst_o=1; all reads return 0000.
  - N=16'h0101 -> same.
  - A following valid start+frame clears ld_err_o.
- Abort: start, 00 03, one word (AB CD), then ld_start_i -> ld_count_o=0 and loaded_len=0. A new frame 00 01 11 22 makes addr0=1122 and addr1=0000.
- Full depth and edge cases:
  - N=256 of incrementing words -> ld_count_o=256; addr 255 returns its word; addr 256 and 16'hFFFF return 0000; rom_ce_i=0 returns 0000.
  - rst asserted mid-load -> RUN with loaded_len=0.
